// File: rtl/demux1x4_n_reg.sv
// ----------------------------------------------------------------------------
// demux1x4_n_reg
// Registered 1-to-4 distributor. Stores DIN into one of four lane registers
// (Q0..Q3), keeps a per-lane fresh-data flag and reports frame status.
//
// Optional feature macro: DEMUX_AUTOINC_EN
//   When defined, a 2-bit write pointer lets AUTO=1 writes fill lanes in
//   sequence. When undefined, AUTO is ignored and SEL always picks the lane.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset
//   DIN      in   BITS  data word to store
//   SEL      in   2     lane for addressed writes
//   WE       in   1     write strobe
//   AUTO     in   1     use internal pointer (DEMUX_AUTOINC_EN only)
//   CONSUME  in   1     clear lane-valid flags, start a new frame
//   Q0..Q3   out  BITS  lane holding registers
//   VALID    out  4     per-lane fresh-data flags
//   FULL     out  1     all four lanes valid (combinational from VALID)
//   OVW      out  1     last write hit an already-valid lane (1-cycle pulse)
//   ESTADO   out  2     00 VAZIO, 01 PARCIAL, 10 CHEIO
// ----------------------------------------------------------------------------
module demux1x4_n_reg #(
   parameter int unsigned BITS = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [BITS-1:0] DIN,
   input  logic [1:0]      SEL,
   input  logic            WE,
   input  logic            AUTO,
   input  logic            CONSUME,
   output logic [BITS-1:0] Q0,
   output logic [BITS-1:0] Q1,
   output logic [BITS-1:0] Q2,
   output logic [BITS-1:0] Q3,
   output logic [3:0]      VALID,
   output logic            FULL,
   output logic            OVW,
   output logic [1:0]      ESTADO
);

   typedef enum logic [1:0] {
      VAZIO   = 2'b00,
      PARCIAL = 2'b01,
      CHEIO   = 2'b10
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [BITS-1:0] r_q [4];
   logic [3:0]      r_valid;
   logic [3:0]      w_valid_nxt;
   logic [3:0]      w_onehot;
   logic            r_ovw;
   logic [1:0]      w_lane;

`ifdef DEMUX_AUTOINC_EN
   logic [1:0] r_ptr;
   logic [1:0] w_ptr_nxt;

   assign w_lane = AUTO ? r_ptr : SEL;

   // Pointer advances only on AUTO writes; a CONSUME+WE write restarts it
   // just past the lane that opened the new frame.
   always_comb begin
      w_ptr_nxt = r_ptr;
      if (WE && AUTO) begin
         w_ptr_nxt = 2'(w_lane + 2'd1);
      end else if (CONSUME) begin
         w_ptr_nxt = 2'd0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ptr <= 2'd0;
      end else begin
         r_ptr <= w_ptr_nxt;
      end
   end
`else
   logic w_unused_auto;

   assign w_unused_auto = AUTO;
   assign w_lane        = SEL;
`endif

   assign w_onehot = 4'b0001 << w_lane;

   // Next lane-valid set; a write alongside CONSUME opens the new frame.
   always_comb begin
      w_valid_nxt = r_valid;
      if (WE && CONSUME) begin
         w_valid_nxt = w_onehot;
      end else if (WE) begin
         w_valid_nxt = r_valid | w_onehot;
      end else if (CONSUME) begin
         w_valid_nxt = 4'b0000;
      end
   end

   // State follows the next VALID value so it lines up with VALID.
   always_comb begin
      w_state_nxt = PARCIAL;
      if (w_valid_nxt == 4'b0000) begin
         w_state_nxt = VAZIO;
      end else if (w_valid_nxt == 4'b1111) begin
         w_state_nxt = CHEIO;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            r_q[i] <= '0;
         end
         r_valid <= 4'b0000;
         r_ovw   <= 1'b0;
         r_state <= VAZIO;
      end else begin
         if (WE) begin
            r_q[w_lane] <= DIN;
         end
         r_valid <= w_valid_nxt;
         r_ovw   <= WE && !CONSUME && r_valid[w_lane];
         r_state <= w_state_nxt;
      end
   end

   assign Q0     = r_q[0];
   assign Q1     = r_q[1];
   assign Q2     = r_q[2];
   assign Q3     = r_q[3];
   assign VALID  = r_valid;
   assign FULL   = &r_valid;
   assign OVW    = r_ovw;
   assign ESTADO = r_state;

endmodule

// File: tb/tb_demux1x4_n_reg.sv
// ----------------------------------------------------------------------------
// tb_demux1x4_n_reg
// Directed plus random stimulus for demux1x4_n_reg. Each step pushes the
// expected post-edge outputs into a queue; they are popped and compared
// one time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_demux1x4_n_reg;

   typedef struct packed {
      logic [3:0] q0;
      logic [3:0] q1;
      logic [3:0] q2;
      logic [3:0] q3;
      logic [3:0] valid;
      logic       full;
      logic       ovw;
      logic [1:0] estado;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] DIN   = 4'h0;
   logic [1:0] SEL   = 2'd0;
   logic       WE    = 1'b0;
   logic       AUTO  = 1'b0;
   logic       CONSUME = 1'b0;
   logic [3:0] Q0, Q1, Q2, Q3;
   logic [3:0] VALID;
   logic       FULL;
   logic       OVW;
   logic [1:0] ESTADO;

   int checks = 0;
   int errors = 0;

   exp_t       sb[$];
   logic [3:0] m_q [4];
   logic [3:0] m_valid = 4'b0000;
   logic       m_ovw   = 1'b0;
   logic [1:0] m_ptr   = 2'd0;

   demux1x4_n_reg #(.BITS(4)) dut (
      .clock(clock), .reset(reset), .DIN(DIN), .SEL(SEL), .WE(WE),
      .AUTO(AUTO), .CONSUME(CONSUME), .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
      .VALID(VALID), .FULL(FULL), .OVW(OVW), .ESTADO(ESTADO)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, advance the reference model, then compare post-edge.
   task automatic step(input logic rst, input logic we, input logic cons,
                       input logic aut, input logic [1:0] sel, input logic [3:0] din);
      exp_t       e;
      exp_t       got;
      logic [1:0] k;
      @(negedge clock);
      reset = rst; WE = we; CONSUME = cons; AUTO = aut; SEL = sel; DIN = din;
`ifdef DEMUX_AUTOINC_EN
      k = aut ? m_ptr : sel;
`else
      k = sel;
`endif
      if (rst) begin
         for (int i = 0; i < 4; i++) m_q[i] = 4'h0;
         m_valid = 4'b0000; m_ovw = 1'b0; m_ptr = 2'd0;
      end else begin
         m_ovw = we && !cons && m_valid[k];
         if (we) m_q[k] = din;
         if (we && cons) m_valid = 4'b0001 << k;
         else if (we) m_valid = m_valid | (4'b0001 << k);
         else if (cons) m_valid = 4'b0000;
`ifdef DEMUX_AUTOINC_EN
         if (we && aut) m_ptr = k + 2'd1;
         else if (cons) m_ptr = 2'd0;
`endif
      end
      e.q0 = m_q[0]; e.q1 = m_q[1]; e.q2 = m_q[2]; e.q3 = m_q[3];
      e.valid = m_valid; e.full = (m_valid == 4'b1111); e.ovw = m_ovw;
      e.estado = (m_valid == 4'b0000) ? 2'b00 : ((m_valid == 4'b1111) ? 2'b10 : 2'b01);
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      got = '{Q0, Q1, Q2, Q3, VALID, FULL, OVW, ESTADO};
      chk("q0", 32'(got.q0), 32'(e.q0));
      chk("q1", 32'(got.q1), 32'(e.q1));
      chk("q2", 32'(got.q2), 32'(e.q2));
      chk("q3", 32'(got.q3), 32'(e.q3));
      chk("valid", 32'(got.valid), 32'(e.valid));
      chk("full", 32'(got.full), 32'(e.full));
      chk("ovw", 32'(got.ovw), 32'(e.ovw));
      chk("estado", 32'(got.estado), 32'(e.estado));
   endtask

   initial begin
      for (int i = 0; i < 4; i++) m_q[i] = 4'h0;

      // Reset with a write pending: the write must be discarded.
      step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'hF);
      chk("rst_valid", 32'(VALID), 32'h0);
      chk("rst_estado", 32'(ESTADO), 32'h0);
      chk("rst_q0", 32'(Q0), 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);

      // Addressed fill.
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'h1);
      chk("fill1_valid", 32'(VALID), 32'b1000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h2);
      chk("fill2_valid", 32'(VALID), 32'b1001);
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 4'h3);
      chk("fill3_valid", 32'(VALID), 32'b1101);
      chk("fill3_full", 32'(FULL), 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'h4);
      chk("fill_q0", 32'(Q0), 32'h2);
      chk("fill_q1", 32'(Q1), 32'h4);
      chk("fill_q2", 32'(Q2), 32'h3);
      chk("fill_q3", 32'(Q3), 32'h1);
      chk("fill_full", 32'(FULL), 32'h1);
      chk("fill_estado", 32'(ESTADO), 32'h2);

      // Overwrite while full: one-cycle OVW pulse.
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 4'h9);
      chk("ovw_q2", 32'(Q2), 32'h9);
      chk("ovw_pulse", 32'(OVW), 32'h1);
      chk("ovw_full", 32'(FULL), 32'h1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
      chk("ovw_drop", 32'(OVW), 32'h0);
      chk("ovw_full_hold", 32'(FULL), 32'h1);

      // CONSUME with simultaneous write opens a new frame.
      step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 4'h7);
      chk("cw_valid", 32'(VALID), 32'b0010);
      chk("cw_q1", 32'(Q1), 32'h7);
      chk("cw_q2", 32'(Q2), 32'h9);
      chk("cw_ovw", 32'(OVW), 32'h0);
      chk("cw_estado", 32'(ESTADO), 32'h1);

      // CONSUME alone from PARCIAL keeps data.
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h5);
      chk("part_valid", 32'(VALID), 32'b0011);
      step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0);
      chk("cons_valid", 32'(VALID), 32'h0);
      chk("cons_estado", 32'(ESTADO), 32'h0);
      chk("cons_q0", 32'(Q0), 32'h5);
      chk("cons_q1", 32'(Q1), 32'h7);

`ifdef DEMUX_AUTOINC_EN
      // Auto mode: five words, pointer wraps onto lane 0.
      step(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 4'hA);
      step(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 4'hB);
      step(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 4'hC);
      step(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 4'hD);
      chk("auto_full4", 32'(FULL), 32'h1);
      chk("auto_ovw4", 32'(OVW), 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 4'hE);
      chk("auto_ovw5", 32'(OVW), 32'h1);
      chk("auto_q0", 32'(Q0), 32'hE);
      chk("auto_q1", 32'(Q1), 32'hB);
      chk("auto_q2", 32'(Q2), 32'hC);
      chk("auto_q3", 32'(Q3), 32'hD);
`else
      // AUTO is ignored: the write must land on SEL.
      step(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 4'hC);
      chk("noauto_q3", 32'(Q3), 32'hC);
      chk("noauto_q0", 32'(Q0), 32'h5);
      chk("noauto_valid", 32'(VALID), 32'b1000);
`endif

      // Random traffic against the model, occasional reset.
      for (int n = 0; n < 60; n++) begin
         step(($urandom_range(0, 29) == 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
              1'($urandom), 2'($urandom), 4'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux1x4_n_reg.md
Name: demux1x4_n_reg

Overview:
- Registered 1-to-4 distributor: the write-side counterpart of the 4x1 selector used in the memory-game datapath.
- Routes one BITS-wide input word into one of four holding registers Q0..Q3, chosen by SEL (or by an internal pointer, see Optional Feature).
- Tracks which lanes hold fresh data and flags when all four are loaded.
- The downstream 4x1 selector reads Q0..Q3, then the consumer issues CONSUME to start a new frame.

Parameters:
- BITS, 4, width of DIN and of each lane register Q0..Q3.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- DIN  input  BITS  data word to store.
- SEL  input  2  target lane for addressed writes (00->Q0 ... 11->Q3).
- WE  input  1  write strobe; one write per cycle while high.
- AUTO  input  1  1 = use internal pointer instead of SEL (only with DEMUX_AUTOINC_EN).
- CONSUME  input  1  clear all lane-valid flags; starts a new frame.
- Q0, Q1, Q2, Q3  output  BITS each  lane holding registers.
- VALID  output  4  per-lane fresh-data flag; bit k refers to Qk.
- FULL  output  1  high when VALID == 4'b1111.
- OVW  output  1  one-cycle pulse: the last write hit a lane that was already valid.
- ESTADO  output  2  FSM state: 00 VAZIO, 01 PARCIAL, 10 CHEIO.

Behaviour:
- Single clock domain; every register updates on the rising edge of clock.
- reset (synchronous, active-high) has highest priority. In the same edge it forces:
  - Q0..Q3 = 0, VALID = 0, OVW = 0, pointer = 0, ESTADO = VAZIO (00).
  - Any write in progress is discarded.
- Target lane k:
  - k = SEL by default.
  - k = pointer only when AUTO=1 and the macro is defined.
- Write (WE=1, CONSUME=0):
  - Qk <= DIN and VALID[k] <= 1 at the next edge; 1-cycle latency.
  - Other lanes are unchanged.
  - OVW <= VALID[k] as sampled before the edge; otherwise OVW <= 0.
- CONSUME=1, WE=0:
  - VALID <= 0 and pointer <= 0.
  - Q0..Q3 keep their values.
  - OVW <= 0.
  - Legal in any state; when not full it acts as an abort.
- CONSUME=1 and WE=1 in the same cycle: the write opens the new frame.
  - VALID <= one-hot(k) and Qk <= DIN.
  - pointer <= k+1 (mod 4) in auto mode, else pointer <= 0.
  - OVW <= 0.
- Idle (WE=0, CONSUME=0): all registers hold; OVW <= 0.
- FULL is combinational from VALID, so it rises in the same cycle the fourth lane's VALID bit rises.
- FSM (registered, derived from the next VALID value):
  - VAZIO: VALID == 0.
  - PARCIAL: VALID nonzero and not all ones.
  - CHEIO: VALID == 1111.
- FSM transitions:
  - VAZIO -> PARCIAL on the first write.
  - PARCIAL -> CHEIO when the last missing lane is written.
  - CHEIO stays CHEIO on further writes; each such write sets OVW.
  - Any state -> VAZIO on CONSUME without WE.
  - Any state -> PARCIAL on CONSUME with WE.
- Width: DIN is stored unmodified. There is no arithmetic except the 2-bit pointer, which wraps 3 -> 0.

Optional Feature:
- Macro: DEMUX_AUTOINC_EN.
- Defined:
  - A 2-bit write pointer exists.
  - A write with AUTO=1 targets lane = pointer, then pointer <= pointer+1 mod 4.
  - A write with AUTO=0 targets SEL and leaves the pointer unchanged.
  - The pointer clears on reset and on CONSUME, with the simultaneous-write exception above.
- Undefined:
  - No pointer logic is synthesized.
  - The AUTO input is ignored; every write targets SEL.
  - All other behaviour is identical.

Test Plan:
- Reset then idle:
  - Assert reset 1 cycle with WE=1, DIN=4'hF.
  - Expect Q0..Q3 = 0, VALID = 0000, FULL = 0, OVW = 0, ESTADO = 00.
- Addressed fill:
  - Write DIN = 1, 2, 3, 4 with SEL = 3, 0, 2, 1 on consecutive cycles.
  - Expect Q0=2, Q1=4, Q2=3, Q3=1.
  - Expect VALID 1000 -> 1001 -> 1101 -> 1111.
  - Expect FULL and ESTADO=10 one edge after the 4th write.
- Overwrite:
  - From full, write DIN=9 with SEL=2.
  - Expect Q2=9, OVW high for exactly 1 cycle, FULL stays 1.
- CONSUME with simultaneous write:
  - From full, assert CONSUME=1, WE=1, SEL=1, DIN=7.
  - Expect VALID=0010, Q1=7, other Q unchanged, OVW=0, ESTADO=01.
- CONSUME alone:
  - From PARCIAL (VALID=0011), pulse CONSUME.
  - Expect VALID=0000, ESTADO=00, Q values retained.
- Auto mode (DEMUX_AUTOINC_EN defined):
  - AUTO=1, write 5 words A, B, C, D, E.
  - Expect Q0=E, Q1=B, Q2=C, Q3=D.
  - Expect FULL after the 4th write and OVW pulse on the 5th (pointer wrapped to 0).
